lfsr_run_ctrl: RTL and testbench
================================

# lfsr_run_ctrl

Sequencing controller for the 3-bit muxed Galois LFSR. It accepts run requests over a valid/ready handshake and drives the LFSR's load/seed inputs: it loads a seed, then advances the LFSR a programmed number of steps, or until a target value appears. It then returns the final value, the step count and status over a second valid/ready handshake. Between runs it holds the LFSR state by reloading the current value.

## Interface
- CNT_W, 8, width of step limit and step counter
- DEFAULT_SEED, 3'b001, seed substituted when a zero seed is requested (must be nonzero)
- clk  in  1  system clock, rising-edge
- arst  in  1  asynchronous reset, active-high
- req_valid  in  1  run request valid
- req_ready  out  1  controller can accept a request
- req_seed  in  3  LFSR seed
- req_steps  in  CNT_W  maximum number of LFSR steps
- req_mode  in  1  0: run exactly req_steps; 1: run until lfsr_q == req_target or req_steps exhausted
- req_target  in  3  match value for mode 1
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_value  out  3  LFSR value at end of run
- rsp_count  out  CNT_W  steps actually taken
- rsp_hit  out  1  mode 1 target matched
- rsp_err  out  2  bit0: zero seed replaced by DEFAULT_SEED; bit1: all-zero lock-up seen during RUN
- lfsr_load  out  1  to LFSR L: 1 = load lfsr_seed on the next edge, 0 = step
- lfsr_seed  out  3  to LFSR r
- lfsr_q  in  3  LFSR state

## Operation
- LFSR step function (polynomial x^3+x^2+1): next[2]=q[0], next[1]=q[2]^q[0], next[0]=q[1]. Period 7: 001,110,011,111,101,100,010,001.
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE: req_ready=1, lfsr_load=1, lfsr_seed=lfsr_q (hold). On req_valid&req_ready, latch seed, steps, mode and target, then go to LOAD. A latched seed of 000 is replaced by DEFAULT_SEED and sets err[0].
- LOAD: lfsr_load=1, lfsr_seed=latched seed. Clear count to 0. Go to RUN.
- RUN: evaluate in priority order:
  1. lfsr_q==000: set err[1], hold, go to RESP.
  2. mode==1 && lfsr_q==target: set hit, hold, go to RESP.
  3. count==steps: hold, go to RESP.
  4. Otherwise: lfsr_load=0 (step) and count++.
- "Hold" means lfsr_load=1 and lfsr_seed=lfsr_q.
- RESP: register rsp_value=lfsr_q, rsp_count=count, rsp_hit and rsp_err on entry, and keep them stable while rsp_valid=1. LFSR is held. On rsp_ready, go to IDLE and clear rsp_valid.
- req_ready=0 in LOAD, RUN and RESP. A request presented then is ignored until IDLE.
- Counter never wraps: the count==steps check precedes any increment. req_steps=0 gives count 0.
- mode 0 ignores req_target. rsp_hit=0 in mode 0.

## Timing
- Request accepted at edge T (IDLE). LOAD occupies cycle T..T+1. First RUN cycle has lfsr_q=seed.
- Steps=N with no early exit: N+1 RUN cycles. rsp_valid rises at edge T+N+3.
- Mode 1 match after k steps: rsp_valid rises at edge T+k+3.
- rsp_valid stays high until the cycle rsp_ready=1. IDLE is entered at that edge, and req_ready=1 in the following cycle. No same-cycle rsp-to-req bypass.
- Reset values (during arst and immediately after):
  - State IDLE.
  - req_ready=1 once arst is low.
  - rsp_valid=0, rsp_value=000, rsp_count=0, rsp_hit=0, rsp_err=00.
  - lfsr_load=1, lfsr_seed=lfsr_q.
- arst mid-run (LOAD/RUN/RESP) aborts the run with no response, and all latched request fields are cleared.

## Test plan
- seed 001, steps 3, mode 0 → rsp_value 111, rsp_count 3, hit 0, err 00; rsp_valid at T+6.
- seed 000, steps 2, mode 0 → seed replaced by 001; rsp_value 011, count 2, err 01.
- seed 001, target 100, steps 10, mode 1 → rsp_value 100, count 5, hit 1; rsp_valid at T+8.
- seed 110, target 000, steps 7, mode 1 → no match; rsp_value 110 (wrapped), count 7, hit 0. Separately, with the bench LFSR model forced to 000 mid-run → err bit1 set and early RESP.
- seed 101, steps 0, with rsp_ready held low 4 cycles:
  - rsp_valid at T+3, value 101, count 0.
  - Outputs stable, req_ready 0, and lfsr_q stays 101 throughout.
  - A second request issued during this window is accepted only after the response handshake.
- arst pulsed during RUN (steps 20) → rsp_valid 0 and all rsp_* zero. req_ready 1 after deassert, and a new request completes normally.

Source files
------------

// File: rtl/lfsr_run_ctrl.sv
// rtl/lfsr_run_ctrl.sv - run sequencer for the 3-bit Galois LFSR: seed load, bounded stepping, result handshake
module lfsr_run_ctrl #(
    parameter int          CNT_W        = 8,
    parameter logic [2:0]  DEFAULT_SEED = 3'b001
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_seed,
    input  logic [CNT_W-1:0] req_steps,
    input  logic             req_mode,
    input  logic [2:0]       req_target,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_value,
    output logic [CNT_W-1:0] rsp_count,
    output logic             rsp_hit,
    output logic [1:0]       rsp_err,
    output logic             lfsr_load,
    output logic [2:0]       lfsr_seed,
    input  logic [2:0]       lfsr_q
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_n;
    logic [2:0]       seed_r;
    logic [2:0]       target_r;
    logic [CNT_W-1:0] steps_r;
    logic [CNT_W-1:0] count;
    logic             mode_r;
    logic             seed_fix;
    logic             hit_f;
    logic             lock_f;
    logic             lock_now;
    logic             hit_now;
    logic             done_now;

    // RUN exit conditions; lock-up outranks a target match, which outranks the step limit
    always_comb begin
        lock_now = (lfsr_q == 3'b000);
        hit_now  = !lock_now && mode_r && (lfsr_q == target_r);
        done_now = lock_now || hit_now || (count == steps_r);
    end

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        lfsr_load = 1'b1;
        lfsr_seed = lfsr_q;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = LOAD;
            end
            LOAD: begin
                lfsr_seed = seed_r;
                state_n   = RUN;
            end
            RUN: begin
                if (done_now) state_n   = RESP;
                else          lfsr_load = 1'b0;
            end
            RESP: begin
                if (rsp_valid && rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            seed_r    <= 3'b000;
            target_r  <= 3'b000;
            steps_r   <= '0;
            mode_r    <= 1'b0;
            seed_fix  <= 1'b0;
            count     <= '0;
            hit_f     <= 1'b0;
            lock_f    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_value <= 3'b000;
            rsp_count <= '0;
            rsp_hit   <= 1'b0;
            rsp_err   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        seed_fix <= (req_seed == 3'b000);
                        seed_r   <= (req_seed == 3'b000) ? DEFAULT_SEED : req_seed;
                        steps_r  <= req_steps;
                        mode_r   <= req_mode;
                        target_r <= req_target;
                    end
                end
                LOAD: count <= '0;
                RUN: begin
                    if (done_now) begin
                        lock_f <= lock_now;
                        hit_f  <= hit_now;
                    end else begin
                        count <= count + ONE;
                    end
                end
                RESP: begin
                    // first RESP cycle captures the held result; it stays frozen until accepted
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_value <= lfsr_q;
                        rsp_count <= count;
                        rsp_hit   <= hit_f;
                        rsp_err   <= {lock_f, seed_fix};
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// tb/tb_lfsr_run_ctrl.sv - self-checking bench for lfsr_run_ctrl with an attached LFSR model
module tb_lfsr_run_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             arst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_seed = 3'b000;
    logic [CNT_W-1:0] req_steps = '0;
    logic             req_mode = 1'b0;
    logic [2:0]       req_target = 3'b000;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [2:0]       rsp_value;
    logic [CNT_W-1:0] rsp_count;
    logic             rsp_hit;
    logic [1:0]       rsp_err;
    logic             lfsr_load;
    logic [2:0]       lfsr_seed;
    logic [2:0]       lfsr_q = 3'b001;

    logic force_zero = 1'b0;
    bit   rand_rr    = 1'b0;
    logic rr_manual  = 1'b1;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_acc = 0;
    int zero_at_next = -1;

    bit         busy = 1'b0;
    int         resp_time = 0;
    logic [2:0] e_val = 3'b000;
    int         e_cnt = 0;
    bit         e_hit = 1'b0;
    logic [1:0] e_err = 2'b00;

    lfsr_run_ctrl #(.CNT_W(CNT_W), .DEFAULT_SEED(3'b001)) dut (
        .clk(clk), .arst(arst),
        .req_valid(req_valid), .req_ready(req_ready), .req_seed(req_seed),
        .req_steps(req_steps), .req_mode(req_mode), .req_target(req_target),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_value(rsp_value),
        .rsp_count(rsp_count), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
        .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_q(lfsr_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] lfsr_step(input logic [2:0] q);
        return {q[0], q[2] ^ q[0], q[1]};
    endfunction

    // external LFSR; force_zero injects the all-zero lock-up state
    always @(posedge clk) begin
        if (force_zero)     lfsr_q <= 3'b000;
        else if (lfsr_load) lfsr_q <= lfsr_seed;
        else                lfsr_q <= lfsr_step(lfsr_q);
    end

    always @(posedge clk) begin
        #2;
        rsp_ready = rand_rr ? 1'($urandom_range(0, 1)) : rr_manual;
    end

    // result of a whole run, computed as a plain loop over LFSR values
    function automatic void run_model(input logic [2:0] seed, input int steps, input bit mode,
                                      input logic [2:0] tgt, input int zero_at,
                                      output logic [2:0] v, output int c, output bit h,
                                      output logic [1:0] e);
        logic [2:0] q;
        q = (seed == 3'b000) ? 3'b001 : seed;
        e = {1'b0, seed == 3'b000};
        c = 0;
        h = 1'b0;
        for (int guard = 0; guard < 1000; guard++) begin
            if (c == zero_at) q = 3'b000;
            if (q == 3'b000) begin e[1] = 1'b1; break; end
            if (mode && q == tgt) begin h = 1'b1; break; end
            if (c == steps) break;
            q = lfsr_step(q);
            c++;
        end
        v = q;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [2:0] v;
        int         c;
        bit         h;
        logic [1:0] e;
        bit         vld;
        if (arst) begin
            busy = 1'b0;
        end else begin
            chk("req_ready", req_ready, !busy);
            vld = busy && (cyc >= resp_time);
            chk("rsp_valid", rsp_valid, vld);
            if (!busy || vld) begin
                chk("lfsr_load_hold", lfsr_load, 1);
                chk("lfsr_seed_hold", lfsr_seed, lfsr_q);
            end
            if (vld) begin
                chk("rsp_value", rsp_value, e_val);
                chk("rsp_count", rsp_count, e_cnt);
                chk("rsp_hit", rsp_hit, e_hit);
                chk("rsp_err", rsp_err, e_err);
                chk("lfsr_q_resp", lfsr_q, e_val);
            end
            if (!busy && req_valid) begin
                run_model(req_seed, int'(req_steps), req_mode, req_target, zero_at_next, v, c, h, e);
                e_val = v; e_cnt = c; e_hit = h; e_err = e;
                resp_time = cyc + 1 + c + 3;
                busy = 1'b1;
            end else if (vld && rsp_ready) begin
                busy = 1'b0;
            end
        end
    end

    task automatic send(input logic [2:0] s, input int n, input logic m, input logic [2:0] t,
                        input int gap);
        bit got = 1'b0;
        repeat (gap) @(posedge clk);
        @(posedge clk);
        #1;
        req_seed = s; req_steps = n[CNT_W-1:0]; req_mode = m; req_target = t; req_valid = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        if (got) begin
            @(posedge clk);
            #1;
            t_acc = cyc;
            req_valid = 1'b0;
        end else begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: got no req_ready expected req_ready=1 within 400 cycles");
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input string name, input logic [2:0] v, input int c, input bit h,
                            input logic [1:0] e, input int lat);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk({name, "_seen"}, seen, 1);
        if (seen) begin
            chk({name, "_value"}, rsp_value, v);
            chk({name, "_count"}, rsp_count, c);
            chk({name, "_hit"}, rsp_hit, h);
            chk({name, "_err"}, rsp_err, e);
            chk({name, "_latency"}, cyc - t_acc, lat);
        end
    endtask

    initial begin
        logic [2:0] v;
        int         c;
        bit         h;
        logic [1:0] e;
        int         t_a;
        bit         idle_ok;

        run_model(3'b001, 3, 1'b0, 3'b000, -1, v, c, h, e);
        chk("pin_a_value", v, 3'b111); chk("pin_a_count", c, 3);
        run_model(3'b000, 2, 1'b0, 3'b000, -1, v, c, h, e);
        chk("pin_b_value", v, 3'b011); chk("pin_b_err", e, 2'b01);
        run_model(3'b001, 10, 1'b1, 3'b100, -1, v, c, h, e);
        chk("pin_c_count", c, 5); chk("pin_c_hit", h, 1);
        run_model(3'b110, 7, 1'b1, 3'b000, -1, v, c, h, e);
        chk("pin_d_value", v, 3'b110); chk("pin_d_hit", h, 0);
        run_model(3'b011, 255, 1'b0, 3'b000, -1, v, c, h, e);
        chk("pin_e_value", v, 3'b100); chk("pin_e_count", c, 255);

        repeat (3) @(posedge clk);
        #3 arst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_value", rsp_value, 0);
        chk("reset_rsp_count", rsp_count, 0);
        chk("reset_rsp_hit", rsp_hit, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_req_ready", req_ready, 1);

        send(3'b001, 3, 1'b0, 3'b000, 0);
        wait_rsp("t1", 3'b111, 3, 1'b0, 2'b00, 6);
        send(3'b000, 2, 1'b0, 3'b000, 0);
        wait_rsp("t2", 3'b011, 2, 1'b0, 2'b01, 5);
        send(3'b001, 10, 1'b1, 3'b100, 0);
        wait_rsp("t3", 3'b100, 5, 1'b1, 2'b00, 8);
        send(3'b110, 7, 1'b1, 3'b000, 0);
        wait_rsp("t4", 3'b110, 7, 1'b0, 2'b00, 10);

        zero_at_next = 3;
        send(3'b110, 7, 1'b0, 3'b000, 0);
        repeat (3) @(posedge clk);
        #1 force_zero = 1'b1;
        @(posedge clk);
        #1 force_zero = 1'b0;
        wait_rsp("t5", 3'b000, 3, 1'b0, 2'b10, 6);
        zero_at_next = -1;

        send(3'b011, 255, 1'b0, 3'b000, 0);
        wait_rsp("t6", 3'b100, 255, 1'b0, 2'b00, 258);

        rr_manual = 1'b0;
        send(3'b101, 0, 1'b0, 3'b000, 0);
        wait_rsp("t7", 3'b101, 0, 1'b0, 2'b00, 3);
        t_a = t_acc;
        fork
            send(3'b001, 1, 1'b0, 3'b000, 0);
            begin
                repeat (3) @(posedge clk);
                #1 rr_manual = 1'b1;
            end
        join
        chk("t7_second_accept", t_acc - t_a, 8);
        wait_rsp("t8", 3'b110, 1, 1'b0, 2'b00, 4);

        send(3'b001, 20, 1'b0, 3'b000, 0);
        repeat (5) @(posedge clk);
        #3 arst = 1'b1;
        @(posedge clk);
        #3 arst = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_value", rsp_value, 0);
        chk("abort_rsp_count", rsp_count, 0);
        chk("abort_rsp_hit", rsp_hit, 0);
        chk("abort_rsp_err", rsp_err, 0);
        chk("abort_req_ready", req_ready, 1);
        send(3'b010, 4, 1'b0, 3'b000, 0);
        wait_rsp("t10", 3'b111, 4, 1'b0, 2'b00, 7);

        rand_rr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(3'($urandom_range(0, 7)), $urandom_range(0, 12), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), $urandom_range(0, 3));
        end
        idle_ok = 1'b0;
        for (int i = 0; i < 300 && !idle_ok; i++) begin
            @(negedge clk);
            if (!busy) idle_ok = 1'b1;
        end
        chk("drain_idle", idle_ok, 1);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
